instruction_fetch: RTL



---
 rtl/instruction_fetch_pkg.sv | 11 +
 rtl/instruction_fetch.sv | 122 ++++++++++++
 2 files changed

// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared constants and FSM encoding for the fetch stage
package instruction_fetch_pkg;
    localparam int INSTR_W = 16;
    localparam logic [15:0] RESET_PC_DEF = 16'h0000;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC plus single-outstanding req/ack instruction memory read with redirect and timeout fault
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int TIMEOUT = 15
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Fetch_En,
    input  logic               Pc_Load,
    input  logic [ADDR_W-1:0]  Pc_Load_Value,
    output logic               Mem_Req,
    output logic [ADDR_W-1:0]  Mem_Addr,
    input  logic               Mem_Ack,
    input  logic [INSTR_W-1:0] Mem_RData,
    output logic [INSTR_W-1:0] Instruction_Out,
    output logic               InstrWrite,
    output logic [ADDR_W-1:0]  PC,
    output logic               Busy,
    output logic               Fault
);
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               req_q, req_d, iw_q, iw_d, busy_q, busy_d, fault_q, fault_d;
    logic [7:0]         cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + 8'd1;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        instr_d = instr_q;
        iw_d    = 1'b0;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (Pc_Load) begin
                    pc_d = Pc_Load_Value;
                end else if (Fetch_En) begin
                    req_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (Mem_Ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (Pc_Load) begin
                        pc_d = Pc_Load_Value;
                    end else begin
                        instr_d = Mem_RData;
                        iw_d    = 1'b1;
                        pc_d    = pc_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO) begin
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else if (Pc_Load) begin
                        pc_d    = Pc_Load_Value;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (Pc_Load) pc_d = Pc_Load_Value;
                if (Mem_Ack) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO) begin
                        req_d   = 1'b0;
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            default: ;
        endcase
        // the outstanding read keeps its original address while a redirect is pending
        addr_d = (state_d == ST_DISCARD) ? addr_q : pc_d;
        busy_d = (state_d == ST_WAIT) || (state_d == ST_DISCARD);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            iw_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            iw_q    <= iw_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end
    assign Mem_Req         = req_q;
    assign Mem_Addr        = addr_q;
    assign Instruction_Out = instr_q;
    assign InstrWrite      = iw_q;
    assign PC              = pc_q;
    assign Busy            = busy_q;
    assign Fault           = fault_q;
endmodule
